// File: rtl/game_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_board_ctrl
// Description : Tic-tac-toe board controller. Holds the 3x3 board, enforces
//               turn order between a human player (player1) and an AI
//               (player2), accepts or rejects moves, and detects win or tie.
// Revision    : 1.0 - initial release
// ============================================================================
module game_board_ctrl (
   input  logic        ph1,
   input  logic        reset,
   input  logic        newGame,
   input  logic        p1Write,
   input  logic [3:0]  p1Addr,
   input  logic        writeToBoard,
   input  logic [3:0]  aiAddr,
   output logic [17:0] gBoard,
   output logic [1:0]  cellState,
   output logic [1:0]  result,
   output logic        moveAccepted,
   output logic        moveRejected
);

   localparam logic [1:0] c_EMPTY     = 2'b00;
   localparam logic [1:0] c_P1_CODE   = 2'b11;
   localparam logic [1:0] c_P2_CODE   = 2'b10;
   localparam logic [1:0] c_TIE       = 2'b01;
   localparam logic [1:0] c_NO_RESULT = 2'b00;
   localparam logic [3:0] c_MAX_CELL  = 4'd8;
   localparam logic [3:0] c_MAX_MOVES = 4'd9;

   typedef enum logic [1:0] {
      P1TURN   = 2'd0,
      P2TURN   = 2'd1,
      CHECK    = 2'd2,
      GAMEOVER = 2'd3
   } state_t;

   state_t      state_q;
   logic [17:0] board_q;
   logic [3:0]  moveCount_q;
   logic [1:0]  result_q;
   logic        acc_q;
   logic        rej_q;
   logic        mover_q;      // 1 = player1 made the last move, 0 = player2

   logic        w_p1Legal;
   logic        w_aiLegal;
   logic [1:0]  w_moverCode;
   logic        w_win;
   logic [17:0] w_p1Board_d;
   logic [17:0] w_aiBoard_d;
   logic [3:0]  w_moveCount_d;

   // Read one cell; addresses beyond the board read as empty (they are
   // rejected by the range test anyway).
   function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] a);
      logic [1:0] c;
      c = c_EMPTY;
      for (int i = 0; i < 9; i++) begin
         if (a == 4'(i)) c = b[2*i +: 2];
      end
      return c;
   endfunction

   // Board with one cell overwritten by the given code.
   function automatic logic [17:0] with_cell(input logic [17:0] b, input logic [3:0] a,
                                             input logic [1:0] code);
      logic [17:0] r;
      r = b;
      for (int i = 0; i < 9; i++) begin
         if (a == 4'(i)) r[2*i +: 2] = code;
      end
      return r;
   endfunction

   // True when any row, column or diagonal is fully owned by the given code.
   function automatic logic has_line(input logic [17:0] b, input logic [1:0] code);
      logic [8:0] m;
      for (int i = 0; i < 9; i++) begin
         m[i] = (b[2*i +: 2] == code);
      end
      return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
             (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
             (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
   endfunction

   // Move legality, candidate next boards and line detection for the last mover.
   always_comb begin
      w_p1Legal     = (p1Addr <= c_MAX_CELL) && (cell_of(board_q, p1Addr) == c_EMPTY);
      w_aiLegal     = (aiAddr <= c_MAX_CELL) && (cell_of(board_q, aiAddr) == c_EMPTY);
      w_p1Board_d   = with_cell(board_q, p1Addr, c_P1_CODE);
      w_aiBoard_d   = with_cell(board_q, aiAddr, c_P2_CODE);
      w_moveCount_d = (moveCount_q == c_MAX_MOVES) ? moveCount_q : moveCount_q + 4'd1;
      w_moverCode   = mover_q ? c_P1_CODE : c_P2_CODE;
      w_win         = has_line(board_q, w_moverCode);
   end

   // Game FSM: turn handling, board writes, end-of-move evaluation and pulses.
   always_ff @(posedge ph1 or posedge reset) begin
      if (reset) begin
         state_q     <= P1TURN;
         board_q     <= '0;
         moveCount_q <= '0;
         result_q    <= c_NO_RESULT;
         acc_q       <= 1'b0;
         rej_q       <= 1'b0;
         mover_q     <= 1'b1;
      end else begin
         acc_q <= 1'b0;
         rej_q <= 1'b0;
         if (newGame) begin
            // Restart wins over any simultaneous strobe, which is dropped silently.
            state_q     <= P1TURN;
            board_q     <= '0;
            moveCount_q <= '0;
            result_q    <= c_NO_RESULT;
            mover_q     <= 1'b1;
         end else begin
            case (state_q)
               P1TURN: begin
                  if (p1Write) begin
                     if (w_p1Legal) begin
                        board_q     <= w_p1Board_d;
                        moveCount_q <= w_moveCount_d;
                        mover_q     <= 1'b1;
                        acc_q       <= 1'b1;
                        state_q     <= CHECK;
                     end else begin
                        rej_q <= 1'b1;
                     end
                  end
               end
               P2TURN: begin
                  if (writeToBoard) begin
                     if (w_aiLegal) begin
                        board_q     <= w_aiBoard_d;
                        moveCount_q <= w_moveCount_d;
                        mover_q     <= 1'b0;
                        acc_q       <= 1'b1;
                        state_q     <= CHECK;
                     end else begin
                        rej_q <= 1'b1;
                     end
                  end
               end
               CHECK: begin
                  // A line completed by the ninth move counts as a win, not a tie.
                  if (w_win) begin
                     result_q <= w_moverCode;
                     state_q  <= GAMEOVER;
                  end else if (moveCount_q == c_MAX_MOVES) begin
                     result_q <= c_TIE;
                     state_q  <= GAMEOVER;
                  end else begin
                     state_q <= mover_q ? P2TURN : P1TURN;
                  end
               end
               GAMEOVER: begin
                  state_q <= GAMEOVER;
               end
               default: begin
                  state_q <= P1TURN;
               end
            endcase
         end
      end
   end

   // Turn indication decoded from the registered state.
   always_comb begin
      case (state_q)
         P1TURN:  cellState = c_P1_CODE;
         P2TURN:  cellState = c_P2_CODE;
         default: cellState = c_EMPTY;
      endcase
   end

   assign gBoard       = board_q;
   assign result       = result_q;
   assign moveAccepted = acc_q;
   assign moveRejected = rej_q;

endmodule
`default_nettype wire

// File: tb/tb_game_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_board_ctrl
// Description : Directed self-checking bench for game_board_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_board_ctrl;

   logic        ph1;
   logic        reset;
   logic        newGame;
   logic        p1Write;
   logic [3:0]  p1Addr;
   logic        writeToBoard;
   logic [3:0]  aiAddr;
   logic [17:0] gBoard;
   logic [1:0]  cellState;
   logic [1:0]  result;
   logic        moveAccepted;
   logic        moveRejected;

   int checks = 0;
   int errors = 0;

   game_board_ctrl dut (
      .ph1          (ph1),
      .reset        (reset),
      .newGame      (newGame),
      .p1Write      (p1Write),
      .p1Addr       (p1Addr),
      .writeToBoard (writeToBoard),
      .aiAddr       (aiAddr),
      .gBoard       (gBoard),
      .cellState    (cellState),
      .result       (result),
      .moveAccepted (moveAccepted),
      .moveRejected (moveRejected)
   );

   initial ph1 = 1'b0;
   always #5 ph1 = ~ph1;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle.
   task automatic step();
      @(posedge ph1);
      #1;
   endtask

   // Play one legal move, then step through the CHECK cycle.
   task automatic play(input logic is_p1, input logic [3:0] a);
      if (is_p1) begin
         p1Write = 1'b1;
         p1Addr  = a;
      end else begin
         writeToBoard = 1'b1;
         aiAddr       = a;
      end
      step();
      check_value("move_acc", 32'(moveAccepted), 32'd1);
      check_value("move_check_state", 32'(cellState), 32'd0);
      p1Write      = 1'b0;
      writeToBoard = 1'b0;
      step();
      check_value("move_acc_drop", 32'(moveAccepted), 32'd0);
   endtask

   task automatic new_game();
      newGame = 1'b1;
      step();
      newGame = 1'b0;
   endtask

   logic [3:0] tie_seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
   logic [3:0] win_seq [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd8, 4'd6};

   initial begin
      reset = 1'b1; newGame = 1'b0; p1Write = 1'b0; p1Addr = 4'd0;
      writeToBoard = 1'b0; aiAddr = 4'd0;
      #2;
      check_value("rst_board", 32'(gBoard), 32'd0);
      check_value("rst_turn", 32'(cellState), 32'h3);
      check_value("rst_result", 32'(result), 32'd0);
      check_value("rst_acc", 32'(moveAccepted), 32'd0);
      check_value("rst_rej", 32'(moveRejected), 32'd0);
      step(); step();
      reset = 1'b0;

      // First move at the centre, then CHECK, then player2's turn.
      p1Write = 1'b1; p1Addr = 4'd4;
      step();
      p1Write = 1'b0;
      check_value("c4_board", 32'(gBoard), 32'h300);
      check_value("c4_acc", 32'(moveAccepted), 32'd1);
      check_value("c4_check", 32'(cellState), 32'd0);
      step();
      check_value("c4_turn2", 32'(cellState), 32'h2);
      check_value("c4_acc_drop", 32'(moveAccepted), 32'd0);

      // Wrong-player strobe is ignored.
      p1Write = 1'b1; p1Addr = 4'd0;
      step();
      p1Write = 1'b0;
      check_value("ign_acc", 32'(moveAccepted), 32'd0);
      check_value("ign_rej", 32'(moveRejected), 32'd0);
      check_value("ign_board", 32'(gBoard), 32'h300);

      // Occupied cell held three cycles: three rejects, board unchanged.
      writeToBoard = 1'b1; aiAddr = 4'd4;
      for (int i = 0; i < 3; i++) begin
         step();
         check_value("occ_rej", 32'(moveRejected), 32'd1);
         check_value("occ_board", 32'(gBoard), 32'h300);
         check_value("occ_turn", 32'(cellState), 32'h2);
      end
      aiAddr = 4'd15;
      step();
      check_value("oob_rej", 32'(moveRejected), 32'd1);
      check_value("oob_acc", 32'(moveAccepted), 32'd0);
      writeToBoard = 1'b0;
      step();
      check_value("rej_drop", 32'(moveRejected), 32'd0);

      // Player1 takes the top row.
      new_game();
      check_value("ng_board", 32'(gBoard), 32'd0);
      check_value("ng_turn", 32'(cellState), 32'h3);
      play(1'b1, 4'd0); play(1'b0, 4'd3); play(1'b1, 4'd1); play(1'b0, 4'd4);
      check_value("row_mid_result", 32'(result), 32'd0);
      play(1'b1, 4'd2);
      check_value("row_result", 32'(result), 32'h3);
      check_value("row_turn", 32'(cellState), 32'd0);
      check_value("row_board", 32'(gBoard),
                  32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11}));
      p1Write = 1'b1; p1Addr = 4'd5; writeToBoard = 1'b1; aiAddr = 4'd6;
      step(); step();
      p1Write = 1'b0; writeToBoard = 1'b0;
      check_value("over_acc", 32'(moveAccepted), 32'd0);
      check_value("over_rej", 32'(moveRejected), 32'd0);
      check_value("over_board", 32'(gBoard),
                  32'({2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11}));
      check_value("over_result", 32'(result), 32'h3);

      // newGame beats a simultaneous move strobe.
      newGame = 1'b1; p1Write = 1'b1; p1Addr = 4'd0;
      step();
      newGame = 1'b0; p1Write = 1'b0;
      check_value("ngp_board", 32'(gBoard), 32'd0);
      check_value("ngp_result", 32'(result), 32'd0);
      check_value("ngp_turn", 32'(cellState), 32'h3);
      check_value("ngp_acc", 32'(moveAccepted), 32'd0);

      // Full board with no line: tie.
      new_game();
      for (int i = 0; i < 9; i++) begin
         play((i % 2) == 0, tie_seq[i]);
         if (i < 8) begin
            check_value("tie_mid_result", 32'(result), 32'd0);
            check_value("tie_mid_turn", 32'(cellState), ((i % 2) == 0) ? 32'h2 : 32'h3);
         end
      end
      check_value("tie_result", 32'(result), 32'h1);
      check_value("tie_turn", 32'(cellState), 32'd0);
      check_value("tie_board", 32'(gBoard),
                  32'({2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11}));

      // Ninth move completes the left column: win, not tie.
      new_game();
      for (int i = 0; i < 9; i++) begin
         play((i % 2) == 0, win_seq[i]);
         if (i < 8) check_value("w9_mid_result", 32'(result), 32'd0);
      end
      check_value("w9_result", 32'(result), 32'h3);
      check_value("w9_board", 32'(gBoard),
                  32'({2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11}));

      // Player2 win on the diagonal 2-4-6.
      new_game();
      play(1'b1, 4'd0); play(1'b0, 4'd2); play(1'b1, 4'd1); play(1'b0, 4'd4);
      play(1'b1, 4'd8); play(1'b0, 4'd6);
      check_value("p2_result", 32'(result), 32'h2);

      // Asynchronous reset while CHECK is in flight.
      new_game();
      p1Write = 1'b1; p1Addr = 4'd0;
      step();
      p1Write = 1'b0;
      check_value("ar_pre_check", 32'(cellState), 32'd0);
      #2 reset = 1'b1;
      #1;
      check_value("ar_board", 32'(gBoard), 32'd0);
      check_value("ar_turn", 32'(cellState), 32'h3);
      check_value("ar_acc", 32'(moveAccepted), 32'd0);
      check_value("ar_result", 32'(result), 32'd0);
      #1 reset = 1'b0;
      step();
      check_value("ar_after_turn", 32'(cellState), 32'h3);
      check_value("ar_after_board", 32'(gBoard), 32'd0);

      // Out-of-range player1 address is rejected.
      p1Write = 1'b1; p1Addr = 4'd12;
      step();
      p1Write = 1'b0;
      check_value("p1_oob_rej", 32'(moveRejected), 32'd1);
      check_value("p1_oob_turn", 32'(cellState), 32'h3);
      play(1'b1, 4'd8);
      check_value("p1_c8_board", 32'(gBoard), 32'h30000);
      check_value("p1_c8_turn", 32'(cellState), 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
